// File: rtl/spr_line_buf_pkg.sv
// Types and constants shared by the sprite line buffer, sprite fetcher and mixer.
package spr_line_buf_pkg;

  localparam int unsigned PixW   = 9;
  localparam int unsigned ColorW = 4;

  typedef logic [PixW-1:0] pixel_t;

  typedef enum logic {StInit, StRun} lb_state_e;

endpackage

// File: rtl/spr_sdp_ram.sv
// Simple dual-port RAM: one synchronous read port, one write port, read-before-write.
module spr_sdp_ram #(
  parameter int unsigned Width = 9,
  parameter int unsigned Depth = 256,
  parameter int unsigned Aw    = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             re_i,
  input  logic [Aw-1:0]    ra_i,
  output logic [Width-1:0] rdata_o,
  input  logic             we_i,
  input  logic [Aw-1:0]    wa_i,
  input  logic [Width-1:0] wdata_i
);

  logic [Width-1:0] mem [Depth];
  logic [Width-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem[wa_i] <= wdata_i;
    if (re_i) rdata_q <= mem[ra_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/spr_line_buf.sv
// Double-buffered sprite line buffer: first-writer-wins fill into one bank while the
// other bank is read and cleared for display. Both banks self-clear after reset.
module spr_line_buf
  import spr_line_buf_pkg::*;
#(
  parameter int unsigned DATA_W  = PixW,
  parameter int unsigned COLOR_W = ColorW,
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned AW      = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              swap,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_x,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_x,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              fill_bank,
  output logic              busy
);

  lb_state_e   st_q, st_d;
  logic [AW-1:0] clr_x_q, clr_x_d;
  logic        fill_bank_q, fill_bank_d;
  logic        run, fill_eff, disp_eff, wr_ok, rd_ok;

  // Fill pipeline S1 register
  logic              s1_vld_q, s1_vld_d, s1_bank_q, s1_bank_d, s1_fwd_q, s1_fwd_d;
  logic [AW-1:0]     s1_x_q, s1_x_d;
  logic [DATA_W-1:0] s1_data_q, s1_data_d, s1_fwd_data_q, s1_fwd_data_d;

  // Display read register; also drives the clear-on-read write
  logic              rd_vld_q, rd_vld_d, rd_bank_q, rd_bank_d, rd_oor_q, rd_oor_d;
  logic              rd_fwd_q, rd_fwd_d;
  logic [AW-1:0]     rd_x_q, rd_x_d;
  logic [DATA_W-1:0] rd_fwd_data_q, rd_fwd_data_d;

  logic [1:0]        ram_we, ram_re;
  logic [AW-1:0]     ram_wa [2];
  logic [AW-1:0]     ram_ra [2];
  logic [DATA_W-1:0] ram_wd [2];
  logic [DATA_W-1:0] ram_rd [2];

  logic [DATA_W-1:0] s1_old;
  logic              fill_we, cor_we;

  if ((1 << AW) == DEPTH) begin : g_pow2
    assign wr_ok = 1'b1;
    assign rd_ok = 1'b1;
  end else begin : g_npow2
    assign wr_ok = 32'(wr_x) < DEPTH;
    assign rd_ok = 32'(rd_x) < DEPTH;
  end

  assign run      = (st_q == StRun);
  // A request coincident with swap already sees the exchanged banks
  assign fill_eff = fill_bank_q ^ (run & swap);
  assign disp_eff = ~fill_eff;

  assign s1_old  = s1_fwd_q ? s1_fwd_data_q : ram_rd[s1_bank_q];
  assign fill_we = s1_vld_q && (s1_old[COLOR_W-1:0] == '0) && (s1_data_q[COLOR_W-1:0] != '0);
  assign cor_we  = rd_vld_q && !rd_oor_q;

  always_comb begin
    for (int b = 0; b < 2; b++) begin
      ram_we[b] = 1'b0;
      ram_wa[b] = '0;
      ram_wd[b] = '0;
      if (!run) begin
        ram_we[b] = 1'b1;
        ram_wa[b] = clr_x_q;
      end else if (fill_we && (s1_bank_q == 1'(b))) begin
        ram_we[b] = 1'b1;
        ram_wa[b] = s1_x_q;
        ram_wd[b] = s1_data_q;
      end else if (cor_we && (rd_bank_q == 1'(b))) begin
        ram_we[b] = 1'b1;
        ram_wa[b] = rd_x_q;
      end
      if (fill_eff == 1'(b)) begin
        ram_re[b] = run && wr_en && wr_ok;
        ram_ra[b] = wr_x;
      end else begin
        ram_re[b] = run && rd_en && rd_ok;
        ram_ra[b] = rd_x;
      end
    end
  end

  always_comb begin
    st_d        = st_q;
    clr_x_d     = clr_x_q;
    fill_bank_d = fill_bank_q;

    // Same-edge writes are invisible to the RAM read, so capture them for forwarding
    s1_vld_d      = run && wr_en && wr_ok;
    s1_bank_d     = fill_eff;
    s1_x_d        = wr_x;
    s1_data_d     = wr_data;
    s1_fwd_d      = ram_we[fill_eff] && (ram_wa[fill_eff] == wr_x);
    s1_fwd_data_d = ram_wd[fill_eff];

    rd_vld_d      = run && rd_en;
    rd_oor_d      = !rd_ok;
    rd_bank_d     = disp_eff;
    rd_x_d        = rd_x;
    rd_fwd_d      = ram_we[disp_eff] && (ram_wa[disp_eff] == rd_x);
    rd_fwd_data_d = ram_wd[disp_eff];

    unique case (st_q)
      StInit: begin
        clr_x_d = clr_x_q + 1'b1;
        if (clr_x_q == AW'(DEPTH - 1)) begin
          st_d    = StRun;
          clr_x_d = '0;
        end
      end
      StRun: begin
        if (swap) fill_bank_d = ~fill_bank_q;
      end
      default: st_d = StInit;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st_q          <= StInit;
      clr_x_q       <= '0;
      fill_bank_q   <= 1'b0;
      s1_vld_q      <= 1'b0;
      s1_bank_q     <= 1'b0;
      s1_x_q        <= '0;
      s1_data_q     <= '0;
      s1_fwd_q      <= 1'b0;
      s1_fwd_data_q <= '0;
      rd_vld_q      <= 1'b0;
      rd_oor_q      <= 1'b0;
      rd_bank_q     <= 1'b0;
      rd_x_q        <= '0;
      rd_fwd_q      <= 1'b0;
      rd_fwd_data_q <= '0;
    end else begin
      st_q          <= st_d;
      clr_x_q       <= clr_x_d;
      fill_bank_q   <= fill_bank_d;
      s1_vld_q      <= s1_vld_d;
      s1_bank_q     <= s1_bank_d;
      s1_x_q        <= s1_x_d;
      s1_data_q     <= s1_data_d;
      s1_fwd_q      <= s1_fwd_d;
      s1_fwd_data_q <= s1_fwd_data_d;
      rd_vld_q      <= rd_vld_d;
      rd_oor_q      <= rd_oor_d;
      rd_bank_q     <= rd_bank_d;
      rd_x_q        <= rd_x_d;
      rd_fwd_q      <= rd_fwd_d;
      rd_fwd_data_q <= rd_fwd_data_d;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    spr_sdp_ram #(
      .Width(DATA_W),
      .Depth(DEPTH),
      .Aw   (AW)
    ) u_ram (
      .clk_i  (clk),
      .re_i   (ram_re[g]),
      .ra_i   (ram_ra[g]),
      .rdata_o(ram_rd[g]),
      .we_i   (ram_we[g]),
      .wa_i   (ram_wa[g]),
      .wdata_i(ram_wd[g])
    );
  end

  assign rd_valid  = rd_vld_q;
  assign rd_data   = cor_we ? (rd_fwd_q ? rd_fwd_data_q : ram_rd[rd_bank_q]) : '0;
  assign fill_bank = fill_bank_q;
  assign busy      = !run;

endmodule

// File: tb/tb_spr_line_buf.sv
// Scoreboard bench for spr_line_buf: a behavioural two-bank model predicts each read.
module tb_spr_line_buf;
  import spr_line_buf_pkg::*;

  logic       clk = 1'b0;
  logic       resetn;
  logic       swap, wr_en, rd_en;
  logic [7:0] wr_x, rd_x;
  pixel_t     wr_data, rd_data;
  logic       rd_valid, fill_bank, busy;

  int unsigned checks = 0;
  int unsigned errors = 0;

  pixel_t mdl [2][256];
  logic   mfb;
  pixel_t exp_q [$];

  spr_line_buf dut (
    .clk      (clk),
    .resetn   (resetn),
    .swap     (swap),
    .wr_en    (wr_en),
    .wr_x     (wr_x),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_x     (rd_x),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .fill_bank(fill_bank),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 256; i++) mdl[b][i] = '0;
    mfb = 1'b0;
    exp_q.delete();
  endtask

  // One cycle of stimulus; the model sees swap first, then the fill, then the read.
  task automatic step(input logic sw, input logic we, input int wx, input pixel_t wd,
                      input logic re, input int rx);
    swap = sw; wr_en = we; wr_x = 8'(wx); wr_data = wd; rd_en = re; rd_x = 8'(rx);
    if (sw) mfb = ~mfb;
    if (we && mdl[mfb][wx][3:0] == 4'h0 && wd[3:0] != 4'h0) mdl[mfb][wx] = wd;
    if (re) begin
      exp_q.push_back(mdl[~mfb][rx]);
      mdl[~mfb][rx] = '0;
    end
    @(posedge clk); #1;
    swap = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic wr(input int x, input pixel_t d); step(1'b0, 1'b1, x, d, 1'b0, 0); endtask
  task automatic rd(input int x);                  step(1'b0, 1'b0, 0, '0, 1'b1, x); endtask
  task automatic sw();                             step(1'b1, 1'b0, 0, '0, 1'b0, 0); endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_rd_valid"}, 32'(rd_valid), 0);
    check_eq({tag, "_rd_data"}, 32'(rd_data), 0);
    check_eq({tag, "_fill_bank"}, 32'(fill_bank), 0);
    check_eq({tag, "_busy"}, 32'(busy), 1);
  endtask

  // Release reset, poke ignored inputs during the clear, and time the busy window.
  task automatic release_and_init(input string tag);
    int n = 0;
    @(negedge clk);
    resetn = 1'b1;
    while (busy && n < 1000) begin
      swap = (n < 10); wr_en = (n < 10); rd_en = (n < 10);
      wr_x = 8'(n); wr_data = 9'h1FF; rd_x = 8'(n);
      @(posedge clk); #1;
      n++;
    end
    swap = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    check_eq({tag, "_busy_cycles"}, 32'(n), 256);
    check_eq({tag, "_fill_bank_after_init"}, 32'(fill_bank), 0);
  endtask

  always @(negedge clk) begin
    if (resetn && rd_valid) begin
      if (exp_q.size() == 0) check_eq("rd_valid_unexpected", 32'(rd_valid), 0);
      else check_eq("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    resetn = 1'b0; swap = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    wr_x = '0; rd_x = '0; wr_data = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    release_and_init("init");

    // Cleared banks
    rd(0); rd(128); rd(255);
    sw();
    rd(0); rd(128); rd(255);
    sw();

    // First-writer-wins, transparent drop
    wr(10, 9'h1A3); wr(10, 9'h0F5); wr(11, 9'h0A0);
    sw();
    check_eq("fill_bank_toggle", 32'(fill_bank), 1);
    rd(10); rd(11);

    // Back-to-back same-x writes
    wr(20, 9'h005); wr(20, 9'h007);
    sw();
    rd(20);

    // Clear-on-read
    wr(5, 9'h0F1);
    sw();
    rd(5); rd(5);
    sw(); sw();
    rd(5);

    // Fill in flight at swap; coincident read of the new display bank
    wr(30, 9'h033);
    step(1'b1, 1'b0, 0, '0, 1'b1, 30);
    wr(31, 9'h0C2);
    step(1'b1, 1'b0, 0, '0, 1'b1, 30);
    step(1'b1, 1'b0, 0, '0, 1'b1, 31);

    // Random mixed traffic over a narrow x range to force collisions
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(15) == 0), $urandom_range(1), $urandom_range(15),
           9'($urandom), $urandom_range(1), $urandom_range(15));
    end
    for (int i = 0; i < 16; i++) wr(i, 9'h1FF);
    sw();
    for (int i = 0; i < 16; i++) wr(i, 9'h1EE);

    // Reset during simultaneous fill and read
    swap = 1'b0; wr_en = 1'b1; wr_x = 8'd3; wr_data = 9'h1DD; rd_en = 1'b1; rd_x = 8'd3;
    @(posedge clk); #1;
    resetn = 1'b0;
    wr_en = 1'b0; rd_en = 1'b0;
    model_clear();
    #1;
    check_reset_vals("midreset");
    repeat (2) @(posedge clk);
    #1;
    release_and_init("reinit");
    for (int i = 0; i < 256; i += 5) rd(i);
    sw();
    for (int i = 0; i < 256; i += 5) rd(i);

    repeat (3) @(posedge clk);
    #1;
    check_eq("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spr_line_buf.md
# spr_line_buf

Parametrised, double-buffered sprite line buffer for the PPU sprite path. While the renderer reads and clears one bank for the current scanline, the sprite fetcher fills the other bank for the next line. Fill uses first-writer-wins priority: an opaque pixel already in the buffer is never overwritten, matching OAM-order priority. A single `swap` pulse per line exchanges the banks, and after reset the block self-clears both banks.

## Interface
Parameters:
- `DATA_W`, 9, pixel word width (palette, priority, colour).
- `COLOR_W`, 4, low bits of the word holding the colour index; the pixel is transparent when these bits are 0.
- `DEPTH`, 256, pixels per line per bank.
- `AW`, `$clog2(DEPTH)`, x-address width (derived).

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock.
- `resetn`  in  1  asynchronous active-low reset.
- `swap`  in  1  single-cycle pulse at line boundary; exchanges fill/display banks.
- `wr_en`  in  1  fill-port write request.
- `wr_x`  in  AW  fill x-address.
- `wr_data`  in  DATA_W  candidate pixel.
- `rd_en`  in  1  display-port read request.
- `rd_x`  in  AW  display x-address.
- `rd_data`  out  DATA_W  pixel read; location cleared after read.
- `rd_valid`  out  1  `rd_data` valid.
- `fill_bank`  out  1  index of the bank currently being filled.
- `busy`  out  1  initial clear in progress.

## Operation
- Two banks, each `DEPTH` x `DATA_W`. Display bank = `~fill_bank`.
- **FSM states:**
  - INIT (reset state): counter `clr_x` sweeps 0..DEPTH-1, writing 0 to both banks in parallel, then moves to RUN.
  - RUN: normal operation.
- **During INIT:** `wr_en`, `rd_en` and `swap` are ignored; `rd_valid` stays 0.
- **Fill pipeline (read-modify-write):**
  - S0: `wr_en` registers the request and reads the fill bank at `wr_x`.
  - S1: old value available. If the old colour bits == 0 and the new colour bits != 0, write `wr_data`; otherwise drop the write.
  - A transparent candidate is never written.
- **Fill forwarding:** if the S1 write (or the committed write of the previous cycle) targets the same x as a newer S0 read, the comparison uses the forwarded value, not RAM. Back-to-back same-x writes must therefore behave as sequential.
- **Display read:** `rd_en` at cycle T returns the display-bank word at T+1. On T+1 the location is written with 0 (clear-on-read). A repeat read of the same x at T+1 returns 0 via forwarding.
- **Swap:**
  - `fill_bank` toggles on the clock edge where `swap`=1.
  - Fill requests already in S0/S1 carry their captured bank and complete into the old fill bank.
  - An `rd_en` coincident with `swap` reads the new display bank.
- **Addresses:** `wr_x`/`rd_x` >= DEPTH (when DEPTH is not a power of two) are ignored: no write, and `rd_data`=0 with `rd_valid`=1.

## Timing
- Reset values:
  - `rd_data`=0, `rd_valid`=0
  - `fill_bank`=0, `busy`=1
  - `clr_x`=0, pipeline valids=0
- `busy` falls exactly DEPTH cycles after the first `clk` edge with `resetn` high.
- Read latency 1 cycle (registered output). The fill write lands 1 cycle after the request and is visible to a read in the next display period.
- Throughput: one fill request and one display read per cycle, simultaneously, with no stalls.
- Reset asserted mid-line: state returns to INIT immediately. RAM contents are not trusted and are re-cleared.

## Structure
- Shared package entries: pixel typedef (`DATA_W` bits) and the `COLOR_W` transparency-field constant. These are shared with the sprite fetcher and the mixer.
- Sub-module `spr_sdp_ram`: simple dual-port RAM (1 sync read port, 1 write port, read-before-write, parametrised depth/width), instantiated once per bank.
- Port muxing in the top level:
  - Fill bank: read port = fill S0 read; write port = S1 write (or INIT clear).
  - Display bank: read port = `rd_x`; write port = clear-on-read (or INIT clear).

## Test plan
- **Init:** release `resetn`. `busy`=1 for 256 cycles then 0; reads of x=0, 128, 255 in both banks after swaps return 0.
- **Priority:** write x=10 with 0x1A3, then x=10 with 0x0F5; swap, read x=10 -> 0x1A3. Write x=11 with colour 0 (0x0A0); read x=11 -> 0.
- **Forwarding:** back-to-back writes x=20 with 0x005 then 0x007, with no idle cycle; after swap, read x=20 -> 0x005.
- **Clear-on-read:** fill x=5 with 0x0F1, swap, read x=5 twice consecutively -> 0x0F1 then 0. Swap twice more; read x=5 -> 0.
- **Swap with fill in flight:** `wr_en` x=30 with 0x033 on the cycle before `swap`. The value appears in the bank displayed after the next swap, not in the new fill bank.
- **Reset mid-operation:** assert `resetn`=0 during simultaneous fill/read. Outputs return to reset values, `busy`=1, and all locations read 0 after INIT.
